// File: rtl/mult_seq_if.sv
// Operand/result bundle for the shift-add multiplier; master issues requests,
// slave (the multiplier) returns hi/lo with busy/done status.
interface mult_seq_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic             sign;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;

    modport master (
        output start, sign, a, b,
        input  hi, lo, busy, done
    );

    modport slave (
        input  start, sign, a, b,
        output hi, lo, busy, done
    );
endinterface

// File: rtl/mult_seq.sv
// Sequential shift-add multiplier for MULT/MULTU: one add/shift step per clock,
// magnitudes multiplied unsigned and the sign applied in a final FIX cycle.
module mult_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic        clock,
    input  logic        reset,
    mult_seq_if.slave   bus
);
    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam int unsigned PW = 2 * WIDTH;

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t            state_q;
    logic [CW-1:0]     count_q;
    logic [WIDTH-1:0]  ma_q;
    logic [PW-1:0]     p_q;
    logic              neg_q;
    logic [WIDTH-1:0]  hi_q;
    logic [WIDTH-1:0]  lo_q;
    logic              busy_q;
    logic              done_q;

    logic [WIDTH-1:0]  mag_a_d;
    logic [WIDTH-1:0]  mag_b_d;
    logic              neg_d;
    logic [WIDTH:0]    upper_d;
    logic [PW-1:0]     p_d;
    logic [PW-1:0]     result_d;

    always_comb begin
        mag_a_d = (bus.sign && bus.a[WIDTH-1]) ? (~bus.a + WIDTH'(1)) : bus.a;
        mag_b_d = (bus.sign && bus.b[WIDTH-1]) ? (~bus.b + WIDTH'(1)) : bus.b;
        neg_d   = bus.sign & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
        // Carry out of the add lands in the top bit after the right shift.
        upper_d = {1'b0, p_q[PW-1:WIDTH]} + (p_q[0] ? {1'b0, ma_q} : '0);
        p_d     = {upper_d, p_q[WIDTH-1:1]};
        result_d = neg_q ? (~p_q + PW'(1)) : p_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            count_q <= '0;
            ma_q    <= '0;
            p_q     <= '0;
            neg_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        ma_q    <= mag_a_d;
                        p_q     <= {{WIDTH{1'b0}}, mag_b_d};
                        neg_q   <= neg_d;
                        count_q <= CW'(WIDTH);
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    p_q     <= p_d;
                    count_q <= count_q - CW'(1);
                    if (count_q == CW'(1)) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    {hi_q, lo_q} <= result_d;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule
